// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling FSM and a
// single-entry holding register with frame-error and overrun pulses.
module uart_rx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       ready,
  output logic [7:0] data,
  output logic       dvalid,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       rx_sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             done_q, done_d;
  logic             stop_ok_q, stop_ok_d;
  logic [7:0]       data_q, data_d;
  logic             dvalid_q, dvalid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             rx_s;

  assign rx_s = rx_sync_q[1];

  // State register, synchronizer and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rx_sync_q   <= 2'b11;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      done_q      <= 1'b0;
      stop_ok_q   <= 1'b0;
      data_q      <= 8'h00;
      dvalid_q    <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_sync_q   <= {rx_sync_q[0], rx};
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      done_q      <= done_d;
      stop_ok_q   <= stop_ok_d;
      data_q      <= data_d;
      dvalid_q    <= dvalid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Frame FSM: the stop sample raises done_q, acted on one cycle later
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    done_d    = 1'b0;
    stop_ok_d = stop_ok_q;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d   = DATA;
            bit_idx_d = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          stop_ok_d = rx_s;
          done_d    = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Holding register: a byte is taken only if the slot is free or being drained
  always_comb begin
    data_d      = data_q;
    dvalid_d    = dvalid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    if (done_q && !stop_ok_q) begin
      frame_err_d = 1'b1;
      dvalid_d    = dvalid_q && !ready;
    end else if (done_q) begin
      if (!dvalid_q || ready) begin
        data_d   = shift_q;
        dvalid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else begin
      dvalid_d = dvalid_q && !ready;
    end
  end

  assign data      = data_q;
  assign dvalid    = dvalid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed vector table, hand-written corner sequences and
// random frames checked every cycle against a frame-level reference model.
module tb_uart_rx;

  localparam int C   = 4;
  localparam int LAT = 3 + C / 2 + 9 * C;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       dvalid;
  logic       frame_err;
  logic       overrun;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .ready     (ready),
    .data      (data),
    .dvalid    (dvalid),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] b;
    bit         ok;
  } ev_t;

  typedef struct {
    logic [7:0] b;
    bit         ok;
    bit         exp_dv;
    bit         exp_fe;
    logic [7:0] exp_data;
  } vec_t;

  ev_t        evq[$];
  vec_t       tbl[8];
  logic [7:0] got[$];
  int         edge_cnt = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  logic       m_dv = 1'b0, m_fe = 1'b0, m_ov = 1'b0;
  logic [7:0] m_data = 8'h00;
  bit         rand_ready = 1'b0;
  int         probe_cyc = -1;
  logic       p_dv = 1'b0, p_fe = 1'b0;
  logic [7:0] p_data = 8'h00;
  int         dv_rise = 0, fe_cnt = 0, ov_cnt = 0;
  logic       prev_dv = 1'b0;
  logic [7:0] rb;
  bit         rok;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s at edge %0d: got 0x%0h expected 0x%0h", name, edge_cnt, act, exp);
    end
  endtask

  // Frame-level reference: each frame resolves LAT edges after its start edge
  task automatic model_step();
    logic       nd, nf, no;
    logic [7:0] ndata;
    ev_t        ev;
    if (reset) begin
      m_dv = 1'b0; m_fe = 1'b0; m_ov = 1'b0; m_data = 8'h00;
      evq.delete();
      return;
    end
    nd    = m_dv && !ready;
    nf    = 1'b0;
    no    = 1'b0;
    ndata = m_data;
    if (evq.size() > 0 && evq[0].cyc == edge_cnt) begin
      ev = evq.pop_front();
      if (!ev.ok) nf = 1'b1;
      else if (!m_dv || ready) begin
        nd    = 1'b1;
        ndata = ev.b;
      end else no = 1'b1;
    end
    m_dv = nd; m_fe = nf; m_ov = no; m_data = ndata;
  endtask

  task automatic tick();
    if (rand_ready) ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    edge_cnt++;
    model_step();
    @(negedge clk);
    check("model", 32'({dvalid, frame_err, overrun, data}), 32'({m_dv, m_fe, m_ov, m_data}));
    if (dvalid && !prev_dv) dv_rise++;
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (dvalid && ready) got.push_back(data);
    prev_dv = dvalid;
    if (edge_cnt == probe_cyc) begin
      p_dv = dvalid; p_fe = frame_err; p_data = data;
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic send_frame(input logic [7:0] b, input bit ok, input int max_ticks);
    logic [9:0] bits;
    int         t;
    bits = {ok, b, 1'b0};
    t    = 0;
    evq.push_back('{edge_cnt + 1 + LAT, b, ok});
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      for (int j = 0; j < C; j++) begin
        if (t < max_ticks) tick();
        t++;
      end
    end
    rx = 1'b1;
  endtask

  task automatic clr_counts();
    dv_rise = 0; fe_cnt = 0; ov_cnt = 0;
  endtask

  initial begin
    tbl[0] = '{8'h41, 1'b1, 1'b1, 1'b0, 8'h41};
    tbl[1] = '{8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[2] = '{8'hFF, 1'b1, 1'b1, 1'b0, 8'hFF};
    tbl[3] = '{8'h80, 1'b1, 1'b1, 1'b0, 8'h80};
    tbl[4] = '{8'h01, 1'b1, 1'b1, 1'b0, 8'h01};
    tbl[5] = '{8'hFF, 1'b0, 1'b0, 1'b1, 8'h01};
    tbl[6] = '{8'h55, 1'b0, 1'b0, 1'b1, 8'h01};
    tbl[7] = '{8'hAA, 1'b1, 1'b1, 1'b0, 8'hAA};

    tick();
    tick();
    check("rst_dvalid", 32'(dvalid), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    idle(3);

    ready = 1'b1;
    foreach (tbl[i]) begin
      clr_counts();
      probe_cyc = edge_cnt + 1 + LAT;
      send_frame(tbl[i].b, tbl[i].ok, 40);
      idle(6);
      check("vec_dvalid", 32'(p_dv), 32'(tbl[i].exp_dv));
      check("vec_frame_err", 32'(p_fe), 32'(tbl[i].exp_fe));
      check("vec_data", 32'(p_data), 32'(tbl[i].exp_data));
      check("vec_dv_pulses", 32'(dv_rise), 32'(tbl[i].exp_dv));
      check("vec_fe_pulses", 32'(fe_cnt), 32'(tbl[i].exp_fe));
    end

    // Two frames back to back with the consumer stalled
    ready = 1'b0;
    clr_counts();
    send_frame(8'h5A, 1'b1, 40);
    send_frame(8'hA5, 1'b1, 40);
    idle(4);
    check("b2b_overrun_pulses", 32'(ov_cnt), 32'd1);
    check("b2b_dv_pulses", 32'(dv_rise), 32'd1);
    check("b2b_dvalid_held", 32'(dvalid), 32'd1);
    check("b2b_data", 32'(data), 32'h5A);
    ready = 1'b1;
    tick();
    check("b2b_accept_clears", 32'(dvalid), 32'd0);
    check("b2b_data_kept", 32'(data), 32'h5A);
    idle(2);

    // One-cycle glitch, then a real frame to show the receiver is back in idle
    clr_counts();
    rx = 1'b0;
    tick();
    idle(12);
    check("glitch_dv", 32'(dv_rise), 32'd0);
    check("glitch_fe", 32'(fe_cnt), 32'd0);
    check("glitch_ov", 32'(ov_cnt), 32'd0);
    probe_cyc = edge_cnt + 1 + LAT;
    send_frame(8'h3C, 1'b1, 40);
    idle(6);
    check("post_glitch_dv", 32'(p_dv), 32'd1);
    check("post_glitch_data", 32'(p_data), 32'h3C);

    // Reset during data bit 4, then a fresh frame three cycles after release
    send_frame(8'h33, 1'b1, 5 * C + 2);
    reset = 1'b1;
    rx    = 1'b1;
    tick();
    tick();
    check("midrst_dvalid", 32'(dvalid), 32'd0);
    check("midrst_data", 32'(data), 32'd0);
    reset = 1'b0;
    idle(3);
    clr_counts();
    send_frame(8'h26, 1'b1, 40);
    idle(6);
    check("midrst_dv_pulses", 32'(dv_rise), 32'd1);
    check("midrst_data_after", 32'(data), 32'h26);
    check("midrst_fe", 32'(fe_cnt), 32'd0);

    // 'A'..'Z' streamed with no idle between frames
    clr_counts();
    got.delete();
    for (int c = 0; c < 26; c++) send_frame(8'(8'h41 + c), 1'b1, 40);
    idle(6);
    check("loop_count", 32'(got.size()), 32'd26);
    for (int c = 0; c < 26 && c < got.size(); c++)
      check("loop_byte", 32'(got[c]), 32'(8'h41 + c));
    check("loop_fe", 32'(fe_cnt), 32'd0);
    check("loop_ov", 32'(ov_cnt), 32'd0);

    // Random bytes, stop errors, gaps and consumer stalls
    rand_ready = 1'b1;
    for (int n = 0; n < 200; n++) begin
      rb  = 8'($urandom);
      rok = ($urandom_range(0, 9) != 0);
      send_frame(rb, rok, 40);
      if (rok) idle($urandom_range(0, 3));
      else idle(4 + $urandom_range(0, 3));
    end
    rand_ready = 1'b0;
    ready      = 1'b1;
    idle(LAT + 5);
    check("final_queue_empty", 32'(evq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
